// File: rtl/trackball_quad_decoder.sv
// Receive side of the trackball dir/clock link: per-axis synchroniser, glitch
// filter and wrapping position counter, with a registered CPU read port.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | synchronised clk matches accepted level L
// ST_FILTER | clk differs from L; counting stable cycles toward accept
// (accept)  | taken from ST_FILTER (or ST_IDLE when FILTER_CYCLES = 1)
//           | in the cycle the count reaches FILTER_CYCLES: L <= s_clk,
//           | step pulse, back to ST_IDLE
module trackball_quad_decoder #(
    parameter int SYNC_STAGES   = 2,
    parameter int FILTER_CYCLES = 4,
    parameter int CNT_W         = 4
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic [3:0] trak_i,
    input  logic       flip_i,
    input  logic       clr_i,
    input  logic       rd_i,
    input  logic       rd_sel_i,
    output logic [7:0] rd_data_o,
    output logic       rd_valid_o,
    output logic       x_step_o,
    output logic       y_step_o
);

    localparam int FW = $clog2(FILTER_CYCLES + 1);

    typedef enum logic {
        ST_IDLE,
        ST_FILTER
    } filt_state_t;

    logic [CNT_W-1:0] cnt_v [2];
    logic [1:0]       ldir_v;
    logic [1:0]       step_v;

    // Axis 0 is X (trak_i[3:2]), axis 1 is Y (trak_i[1:0]).
    for (genvar a = 0; a < 2; a++) begin : g_axis
        logic [SYNC_STAGES-1:0] sclk_q, sdir_q;
        logic                   s_clk, s_dir, step_dir;
        filt_state_t            state_q, state_d;
        logic [FW-1:0]          fcnt_q, fcnt_d;
        logic                   lvl_q, lvl_d;
        logic                   accept;
        logic [CNT_W-1:0]       cnt_q;
        logic                   ldir_q;
        logic                   step_q;

        assign s_clk    = sclk_q[SYNC_STAGES-1];
        assign s_dir    = sdir_q[SYNC_STAGES-1];
        assign step_dir = s_dir ^ flip_i;

        always_ff @(posedge clk_sys or posedge reset) begin
            if (reset) begin
                sclk_q  <= '0;
                sdir_q  <= '0;
                state_q <= ST_IDLE;
                fcnt_q  <= '0;
                lvl_q   <= 1'b0;
            end else begin
                sclk_q  <= {sclk_q[SYNC_STAGES-2:0], trak_i[2-2*a]};
                sdir_q  <= {sdir_q[SYNC_STAGES-2:0], trak_i[3-2*a]};
                state_q <= state_d;
                fcnt_q  <= fcnt_d;
                lvl_q   <= lvl_d;
            end
        end

        always_comb begin
            state_d = state_q;
            fcnt_d  = fcnt_q;
            lvl_d   = lvl_q;
            accept  = 1'b0;
            case (state_q)
                ST_IDLE: begin
                    fcnt_d = '0;
                    if (s_clk != lvl_q) begin
                        if (FILTER_CYCLES == 1) begin
                            accept = 1'b1;
                            lvl_d  = s_clk;
                        end else begin
                            state_d = ST_FILTER;
                            fcnt_d  = FW'(1);
                        end
                    end
                end
                ST_FILTER: begin
                    if (s_clk == lvl_q) begin
                        state_d = ST_IDLE;
                        fcnt_d  = '0;
                    end else if (fcnt_q == FW'(FILTER_CYCLES - 1)) begin
                        accept  = 1'b1;
                        lvl_d   = s_clk;
                        state_d = ST_IDLE;
                        fcnt_d  = '0;
                    end else begin
                        fcnt_d = fcnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    fcnt_d  = '0;
                end
            endcase
        end

        // Clear wins over a coincident step; the step pulse still fires.
        always_ff @(posedge clk_sys or posedge reset) begin
            if (reset) begin
                cnt_q  <= '0;
                ldir_q <= 1'b0;
                step_q <= 1'b0;
            end else begin
                step_q <= accept;
                if (clr_i) begin
                    cnt_q <= '0;
                end else if (accept) begin
                    cnt_q  <= step_dir ? cnt_q + 1'b1 : cnt_q - 1'b1;
                    ldir_q <= step_dir;
                end
            end
        end

        assign cnt_v[a]  = cnt_q;
        assign ldir_v[a] = ldir_q;
        assign step_v[a] = step_q;
    end

    assign x_step_o = step_v[0];
    assign y_step_o = step_v[1];

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            rd_data_o  <= 8'h00;
            rd_valid_o <= 1'b0;
        end else begin
            rd_valid_o <= rd_i;
            if (rd_i)
                rd_data_o <= {ldir_v[rd_sel_i], 7'(cnt_v[rd_sel_i])};
        end
    end

endmodule
